// File: rtl/prores_scan_pkg.sv
// rtl/prores_scan_pkg.sv - shared types and the progressive scan table for slice scan reading
package prores_scan_pkg;

  localparam int BLOCK_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Progressive coefficient order within an 8x8 block: entry p is the raster index emitted at scan position p.
  localparam logic [5:0] SCAN_PROGRESSIVE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/slice_scan_counter.sv
// rtl/slice_scan_counter.sv - scan position / block counters with wrap and last-beat detection
module slice_scan_counter
  import prores_scan_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  input  logic [5:0] n_in,
  output logic [5:0] pos,
  output logic [4:0] blk,
  output logic       last,
  output logic [5:0] nxt_pos,
  output logic [4:0] nxt_blk
);

  logic [5:0] n;
  logic [5:0] nxt_n;

  // The next beat is exposed combinationally so the parent can fetch its data in the same edge that registers it.
  always_comb begin
    nxt_pos = pos;
    nxt_blk = blk;
    nxt_n   = n;
    if (clear) begin
      nxt_pos = '0;
      nxt_blk = '0;
      nxt_n   = n_in;
    end else if (advance) begin
      if ({1'b0, blk} == n - 6'd1) begin
        nxt_blk = '0;
        nxt_pos = pos + 6'd1;
      end else begin
        nxt_blk = blk + 5'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos  <= '0;
      blk  <= '0;
      n    <= '0;
      last <= 1'b0;
    end else if (clear || advance) begin
      pos  <= nxt_pos;
      blk  <= nxt_blk;
      n    <= nxt_n;
      last <= (nxt_pos == 6'(BLOCK_WORDS - 1)) && ({1'b0, nxt_blk} == nxt_n - 6'd1);
    end
  end

endmodule

// File: rtl/slice_scan_reader.sv
// rtl/slice_scan_reader.sv - streams a slice coefficient buffer in progressive scan order, DC terms first
module slice_scan_reader
  import prores_scan_pkg::*;
#(
  parameter int NUM_WORDS  = 2048,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BLOCKS = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            num_blocks,
  input  logic [DATA_WIDTH-1:0] input_data [NUM_WORDS],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [5:0]            out_pos,
  output logic [4:0]            out_block,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  state_t      state;
  logic        clear;
  logic        advance;
  logic [5:0]  n_clamped;
  logic [5:0]  nxt_pos;
  logic [4:0]  nxt_blk;
  logic [10:0] addr;

  assign n_clamped = (num_blocks > 6'(MAX_BLOCKS)) ? 6'(MAX_BLOCKS) : num_blocks;
  assign clear     = (state == IDLE) && start && (num_blocks != 6'd0);
  assign advance   = (state == RUN) && out_valid && out_ready && !out_last;

  // Block base is a multiple of 64, so OR-ing in the in-block offset equals blk*64 + SCAN[pos].
  assign addr = {nxt_blk, 6'b0} | {5'b0, SCAN_PROGRESSIVE[nxt_pos]};

  slice_scan_counter u_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .advance (advance),
    .n_in    (n_clamped),
    .pos     (out_pos),
    .blk     (out_block),
    .last    (out_last),
    .nxt_pos (nxt_pos),
    .nxt_blk (nxt_blk)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (num_blocks == 6'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_data  <= input_data[addr];
            end
          end
        end
        RUN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_data <= input_data[addr];
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_scan_reader.sv
// tb/tb_slice_scan_reader.sv - directed self-checking bench for slice_scan_reader
module tb_slice_scan_reader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [5:0]  num_blocks;
  logic [31:0] mem [2048];
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_pos;
  logic [4:0]  out_block;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_checks;
  int n_pass;

  int scan [64] = '{
    0,  1,  8,  9,  2,  3,  10, 11,
    16, 17, 24, 25, 18, 19, 26, 27,
    4,  5,  12, 20, 13, 6,  7,  14,
    21, 28, 29, 22, 15, 23, 30, 31,
    32, 33, 40, 48, 41, 34, 35, 42,
    49, 56, 57, 50, 43, 36, 37, 44,
    51, 58, 59, 52, 45, 38, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  slice_scan_reader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_blocks (num_blocks),
    .input_data (mem),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_pos    (out_pos),
    .out_block  (out_block),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Starts a slice and consumes beats until the slice ends or stop_after handshakes have occurred.
  task automatic run_slice(input int n_req, input int n_eff, input bit stall, input bit inject,
                           input int stop_after);
    int total;
    int k;
    int cyc;
    int want;
    int exp_pos;
    int exp_blk;
    total = 64 * n_eff;
    want  = (stop_after < total) ? stop_after : total;
    k     = 0;
    cyc   = 0;
    @(negedge clock);
    start      = 1'b1;
    num_blocks = 6'(n_req);
    @(negedge clock);
    start = 1'b0;
    check("first_valid", 32'(out_valid), 32'd1);
    check("busy_run", 32'(busy), 32'd1);
    while (k < want && cyc < total * 3 + 20) begin
      out_ready = stall ? (cyc % 2 == 0) : 1'b1;
      if (inject && cyc == 7) begin
        start      = 1'b1;
        num_blocks = 6'd1;
      end else begin
        start = 1'b0;
      end
      exp_pos = k / n_eff;
      exp_blk = k % n_eff;
      check("valid", 32'(out_valid), 32'd1);
      check("data", out_data, 32'(exp_blk * 64 + scan[exp_pos]));
      check("pos", 32'(out_pos), 32'(exp_pos));
      check("block", 32'(out_block), 32'(exp_blk));
      check("last", 32'(out_last), 32'(k == total - 1));
      if (out_valid && out_ready) k++;
      @(negedge clock);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("beat_count", 32'(k), 32'(want));
    if (want == total) begin
      check("done_pulse", 32'(done), 32'd1);
      check("busy_end", 32'(busy), 32'd0);
      check("valid_end", 32'(out_valid), 32'd0);
      @(negedge clock);
      check("done_single", 32'(done), 32'd0);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    num_blocks = 6'd0;
    out_ready  = 1'b1;
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i);

    @(negedge clock);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_slice(1, 1, 1'b0, 1'b0, 100000);
    run_slice(2, 2, 1'b0, 1'b0, 100000);
    run_slice(2, 2, 1'b1, 1'b1, 100000);

    @(negedge clock);
    start      = 1'b1;
    num_blocks = 6'd0;
    @(negedge clock);
    start = 1'b0;
    check("empty_done", 32'(done), 32'd1);
    check("empty_valid", 32'(out_valid), 32'd0);
    check("empty_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("empty_done_drop", 32'(done), 32'd0);
    check("empty_valid2", 32'(out_valid), 32'd0);

    run_slice(40, 32, 1'b0, 1'b0, 100000);

    run_slice(2, 2, 1'b0, 1'b0, 10);
    reset = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run_slice(1, 1, 1'b0, 1'b0, 100000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
